// File: rtl/exeu_pkg.sv
// Shared definitions for the multi-cycle execute unit.
//   - op-code values carried on alu_op
//   - FSM state encoding
//   - default alu_op field width
package exeu_pkg;

  localparam int unsigned ALUOP_WIDTH_DEF = 4;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 5;
  localparam int unsigned OP_SRL  = 6;
  localparam int unsigned OP_SRA  = 7;
  localparam int unsigned OP_SLT  = 8;
  localparam int unsigned OP_SLTU = 9;
  localparam int unsigned OP_MUL  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exeu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load op_a (multiplicand) / op_b (multiplier), clear acc
//   busy       : iteration in progress (count != 0)
//   done       : this cycle performs the final step; product is valid now
//   product    : acc plus the current partial product (low DATA_WIDTH bits)
module exeu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] addend;
  logic [CW-1:0]         count;

  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign busy    = (count != '0);
  // The step taken while count==1 is the last one, so the sum it writes
  // is presented combinationally for the parent to capture on that edge.
  assign done    = (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      count  <= CW'(DATA_WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/exeu_mc.sv
// Multi-cycle execute stage with valid/ready handshakes on both sides.
// Ten single-cycle ALU ops plus an optional iterative multiplier; the result
// is registered for the register-file write port.
//   in_valid/in_ready   : upstream handshake carrying alu_op, operands, rd
//   out_valid/out_ready : downstream handshake for the registered result
//   wrtbck_val_o, rd_o, wrtbck_en_o : writeback value, index, enable
// Build option: define EXEU_MC_MUL_EN to build the MUL datapath (BUSY state);
// when undefined, MUL is handled as an illegal op.
module exeu_mc
  import exeu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALUOP_WIDTH    = ALUOP_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALUOP_WIDTH-1:0]    alu_op,
  input  logic [DATA_WIDTH-1:0]     rs1_val,
  input  logic [DATA_WIDTH-1:0]     rs2_val,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      use_rd,
  input  logic                      use_rs1,
  input  logic                      use_rs2,
  input  logic                      use_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     wrtbck_val_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic                      wrtbck_en_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  state_t                state, state_nxt;
  logic                  accept;
  logic                  is_mul;
  logic                  legal;
  logic [DATA_WIDTH-1:0] op1, op2, alu_result;
  logic [SHW-1:0]        shamt;

  assign op1   = use_rs1 ? rs1_val : '0;
  assign op2   = use_rs2 ? rs2_val : (use_imm ? imm : '0);
  assign shamt = op2[SHW-1:0];

`ifdef EXEU_MC_MUL_EN
  logic                  mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  assign is_mul = (alu_op == ALUOP_WIDTH'(OP_MUL));
  assign legal  = (alu_op <= ALUOP_WIDTH'(OP_MUL));

  exeu_mul_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept & is_mul),
    .op_a    (op1),
    .op_b    (op2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul = 1'b0;
  assign legal  = (alu_op <= ALUOP_WIDTH'(OP_SLTU));
`endif

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALUOP_WIDTH'(OP_ADD):  alu_result = op1 + op2;
      ALUOP_WIDTH'(OP_SUB):  alu_result = op1 - op2;
      ALUOP_WIDTH'(OP_AND):  alu_result = op1 & op2;
      ALUOP_WIDTH'(OP_OR):   alu_result = op1 | op2;
      ALUOP_WIDTH'(OP_XOR):  alu_result = op1 ^ op2;
      ALUOP_WIDTH'(OP_SLL):  alu_result = op1 << shamt;
      ALUOP_WIDTH'(OP_SRL):  alu_result = op1 >> shamt;
      ALUOP_WIDTH'(OP_SRA):  alu_result = DATA_WIDTH'($signed(op1) >>> shamt);
      ALUOP_WIDTH'(OP_SLT):  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALUOP_WIDTH'(OP_SLTU): alu_result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      default:               alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
`ifdef EXEU_MC_MUL_EN
      BUSY: begin
        if (mul_done)      state_nxt = DONE;
        else if (!mul_busy) state_nxt = IDLE;
      end
`endif
      DONE: begin
        in_ready = out_ready;
        if (out_ready && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_nxt = is_mul ? BUSY : DONE;
  end

  assign out_valid = (state == DONE);

  // rd_o / wrtbck_en_o are loaded at accept even for MUL; out_valid is low
  // through BUSY so the early update is never observed as a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrtbck_val_o <= '0;
      rd_o         <= '0;
      wrtbck_en_o  <= 1'b0;
    end else if (accept) begin
      rd_o        <= rd;
      wrtbck_en_o <= use_rd & (rd != '0) & legal;
      if (!is_mul) wrtbck_val_o <= alu_result;
    end
`ifdef EXEU_MC_MUL_EN
    else if (state == BUSY && mul_done) begin
      wrtbck_val_o <= mul_product;
    end
`endif
  end

endmodule

// File: tb/tb_exeu_mc.sv
module tb_exeu_mc;

`ifdef EXEU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  alu_op;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rd;
  logic        use_rd, use_rs1, use_rs2, use_imm;
  logic        out_valid, out_ready;
  logic [31:0] wrtbck_val_o;
  logic [4:0]  rd_o;
  logic        wrtbck_en_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  rd;
    logic        en;
    int          lat;
  } exp_t;

  exp_t sb[$];

  exeu_mc #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rd(rd),
    .use_rd(use_rd), .use_rs1(use_rs1), .use_rs2(use_rs2), .use_imm(use_imm),
    .out_valid(out_valid), .out_ready(out_ready), .wrtbck_val_o(wrtbck_val_o),
    .rd_o(rd_o), .wrtbck_en_o(wrtbck_en_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = MUL_EN ? a * b : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sb.size() == 0) begin
      e.val = 'x; e.rd = 'x; e.en = 1'bx; e.lat = -1;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Present one instruction and record its expected result.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] d, input logic urd,
                       input logic u1, input logic u2, input logic ui);
    exp_t e;
    logic [31:0] o1, o2;
    alu_op = op; rs1_val = a; rs2_val = b; imm = im; rd = d;
    use_rd = urd; use_rs1 = u1; use_rs2 = u2; use_imm = ui;
    in_valid = 1'b1;
    o1 = u1 ? a : 32'd0;
    o2 = u2 ? b : (ui ? im : 32'd0);
    e.val = model(op, o1, o2);
    e.rd  = d;
    e.en  = urd && (d != 5'd0) && ((op <= 4'd9) || (op == 4'd10 && MUL_EN));
    e.lat = (op == 4'd10 && MUL_EN) ? 32 : 1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (wrtbck_val_o !== 32'd0) begin n_err++; $display("FAIL reset_val: got %h want 0", wrtbck_val_o); end
    n_cmp++; if (rd_o !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", rd_o); end
    n_cmp++; if (wrtbck_en_o !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", wrtbck_en_o); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    exp_t e;
    out_ready = 1'b1;
    drive(4'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    e = pop_exp();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (wrtbck_val_o !== e.val || e.val !== 32'd2) begin n_err++; $display("FAIL add_val: got %h want %h", wrtbck_val_o, e.val); end
    n_cmp++; if (rd_o !== e.rd) begin n_err++; $display("FAIL add_rd: got %0d want %0d", rd_o, e.rd); end
    n_cmp++; if (wrtbck_en_o !== e.en) begin n_err++; $display("FAIL add_en: got %b want %b", wrtbck_en_o, e.en); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'd1, 4'd8, 4'd9, 4'd7};
    logic [31:0] as  [4] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd5, 32'd1, 32'd1, 32'd4};
    exp_t e;
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin
        e = pop_exp();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", c-1, out_valid); end
        n_cmp++; if (wrtbck_val_o !== e.val) begin n_err++; $display("FAIL b2b_val[%0d]: got %h want %h", c-1, wrtbck_val_o, e.val); end
        n_cmp++; if (rd_o !== e.rd) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", c-1, rd_o, e.rd); end
      end
      if (c < 4) drive(ops[c], as[c], bs[c], 32'd0, 5'(c + 1), 1'b1, 1'b1, 1'b1, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_single_ops();
    logic [3:0]  ops [9] = '{4'd7, 4'd8, 4'd0, 4'd5, 4'd6, 4'd10, 4'd10, 4'd10, 4'd10};
    logic [31:0] as  [9] = '{32'h8765_4321, 32'h8000_0000, 32'd99, 32'd1, 32'h8000_0000,
                             32'h0000_FFFF, 32'h1234_5678, 32'h1234_5678, 32'd7};
    logic [31:0] bs  [9] = '{32'd0, 32'd0, 32'd5, 32'd31, 32'd35,
                             32'h0001_0001, 32'd0, 32'hFFFF_FFFF, 32'd6};
    logic        u1s [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int   cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(ops[i], as[i], bs[i], 32'd0, 5'd3, 1'b1, u1s[i], 1'b1, 1'b0);
      cyc = 0;
      do begin
        @(negedge clk); in_valid = 1'b0; cyc++;
        if (!out_valid) begin
          n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL op%0d_busy_ready: got %b want 0", i, in_ready); end
        end
      end while (!out_valid && cyc < 100);
      e = pop_exp();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL op%0d_timeout: out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL op%0d_latency: got %0d want %0d", i, cyc, e.lat); end
      n_cmp++; if (wrtbck_val_o !== e.val) begin n_err++; $display("FAIL op%0d_val: got %h want %h", i, wrtbck_val_o, e.val); end
      n_cmp++; if (wrtbck_en_o !== e.en) begin n_err++; $display("FAIL op%0d_en: got %b want %b", i, wrtbck_en_o, e.en); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    drive(4'd4, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 32'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
    e = sb[$];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
      n_cmp++; if (wrtbck_val_o !== e.val || rd_o !== e.rd) begin n_err++; $display("FAIL bp_hold[%0d]: got %h/%0d want %h/%0d", k, wrtbck_val_o, rd_o, e.val, e.rd); end
    end
    out_ready = 1'b1;
    e = pop_exp();
    n_cmp++; if (wrtbck_val_o !== e.val || wrtbck_en_o !== e.en) begin n_err++; $display("FAIL bp_xfer: got %h/%b want %h/%b", wrtbck_val_o, wrtbck_en_o, e.val, e.en); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle: valid/ready got %b/%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_wen();
    exp_t e;
    out_ready = 1'b1;
    drive(4'd0, 32'd1, 32'd2, 32'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    e = pop_exp();
    n_cmp++; if (out_valid !== 1'b1 || wrtbck_en_o !== e.en || wrtbck_val_o !== e.val) begin n_err++; $display("FAIL wen_rd0: v/en/val got %b/%b/%h want 1/%b/%h", out_valid, wrtbck_en_o, wrtbck_val_o, e.en, e.val); end
    drive(4'd13, 32'd9, 32'd4, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    e = pop_exp();
    n_cmp++; if (out_valid !== 1'b1 || wrtbck_en_o !== e.en || wrtbck_val_o !== e.val) begin n_err++; $display("FAIL wen_illegal: v/en/val got %b/%b/%h want 1/%b/%h", out_valid, wrtbck_en_o, wrtbck_val_o, e.en, e.val); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    out_ready = 1'b0;
    drive(4'd2, 32'hFFFF_0000, 32'h00FF_FF00, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || wrtbck_val_o !== 32'd0 || rd_o !== 5'd0 || wrtbck_en_o !== 1'b0) begin n_err++; $display("FAIL rst_done: v/val/rd/en got %b/%h/%0d/%b want 0/0/0/0", out_valid, wrtbck_val_o, rd_o, wrtbck_en_o); end
    sb.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
`ifdef EXEU_MC_MUL_EN
    drive(4'd10, 32'd1234, 32'd5678, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) begin @(negedge clk); in_valid = 1'b0; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || wrtbck_val_o !== 32'd0 || rd_o !== 5'd0 || wrtbck_en_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: v/val/rd/en got %b/%h/%0d/%b want 0/0/0/0", out_valid, wrtbck_val_o, rd_o, wrtbck_en_o); end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
`endif
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_stale: out_valid seen %b want 0", seen); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; rs1_val = '0; rs2_val = '0; imm = '0; rd = '0;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_imm = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_single_ops();
    test_backpressure();
    test_wen();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exeu_mc.md
Name: exeu_mc

Overview:
- Parametrised successor to the single-cycle execute unit: a multi-cycle execute stage with valid/ready handshakes on both sides.
- Widens the ALU to ten single-cycle ops plus an iterative shift-add multiplier.
- Registers the result for the writeback/register-file port.
- Sits between the decode unit (source of operand fields) and the register-file write port of the decode unit.

Parameters:
DATA_WIDTH, 32, operand/result width; legal values 32 or 64
REG_ADDR_WIDTH, 5, destination register index width
ALUOP_WIDTH, 4, alu_op field width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an instruction
in_ready  out  1  block accepts the instruction this cycle
alu_op  in  ALUOP_WIDTH  operation code (codes in package)
rs1_val  in  DATA_WIDTH  source 1 value
rs2_val  in  DATA_WIDTH  source 2 value
imm  in  DATA_WIDTH  sign-extended immediate
rd  in  REG_ADDR_WIDTH  destination index
use_rd  in  1  instruction writes rd
use_rs1  in  1  operand 1 is rs1_val
use_rs2  in  1  operand 2 is rs2_val
use_imm  in  1  operand 2 is imm (when use_rs2=0)
out_valid  out  1  result registered and valid
out_ready  in  1  downstream takes the result
wrtbck_val_o  out  DATA_WIDTH  result value
rd_o  out  REG_ADDR_WIDTH  destination index
wrtbck_en_o  out  1  write enable for the register file

Behaviour:
- Clocking and reset (decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, wrtbck_val_o=0, rd_o=0, wrtbck_en_o=0, multiplier count=0.
- Operand select (at accept):
  - op1 = use_rs1 ? rs1_val : 0
  - op2 = use_rs2 ? rs2_val : use_imm ? imm : 0
- Op codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4
  - SLL=5, SRL=6, SRA=7: shift by op2[log2(DATA_WIDTH)-1:0]
  - SLT=8 (signed), SLTU=9: result is 0 or 1, zero-extended
  - MUL=10: low DATA_WIDTH bits of the product
  - Codes 11..15 are illegal.
- All arithmetic is modulo 2^DATA_WIDTH; no overflow flag.
- wrtbck_en_o = use_rd & (rd!=0) & legal op.
- An illegal op still completes in 1 cycle with result 0 and wrtbck_en_o=0.
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Once out_valid rises, wrtbck_val_o/rd_o/wrtbck_en_o stay stable until out_ready is sampled high.
- States:
  - IDLE:
    - accept a non-MUL op → DONE, result registered next edge (latency 1).
    - accept MUL → BUSY, load multiplicand=op1, multiplier=op2, acc=0, count=DATA_WIDTH.
  - BUSY, each cycle:
    - if multiplier[0], acc += multiplicand
    - multiplicand <<= 1; multiplier >>= 1; count -= 1
    - when count reaches 1, the final step writes the result → DONE
    - MUL latency from accept to out_valid is DATA_WIDTH cycles; in_ready=0 throughout.
  - DONE: out_valid=1. On out_ready:
    - with in_valid: accept the new op (back-to-back, one result per cycle for ALU ops) → DONE or BUSY.
    - without in_valid: → IDLE.
- Boundary cases:
  - MUL with op2=0 still takes the full DATA_WIDTH cycles (fixed latency).
  - Multiplication by -1 yields the two's complement of op1.
  - SRA by 0 passes op1 unchanged.
  - SLT with op1=minimum negative, op2=0 gives 1.
- Reset mid-BUSY or mid-DONE: the in-flight result is discarded; no out_valid pulse after reset.
- in_valid is ignored while in_ready=0; upstream holds its fields.

Optional Feature:
- Macro EXEU_MC_MUL_EN.
- Defined: MUL as above; the BUSY state, counter and shift registers are present.
- Undefined:
  - BUSY logic is not built.
  - MUL is treated as illegal: 1-cycle completion, result 0, wrtbck_en_o=0.
  - in_ready never drops except in DONE without out_ready.

Decomposition:
- Shared package exeu_pkg holds:
  - the op-code localparams (ADD..MUL)
  - the state encoding (IDLE=0, BUSY=1, DONE=2)
  - the ALUOP_WIDTH default
- One sub-module, exeu_mul_iter: the iterative multiplier with start/busy/done and a DATA_WIDTH parameter.
- ALU combinational logic stays in exeu_mc.

Test Plan:
- ADD: rs1_val=5, use_imm=1, imm=-3, rd=7, use_rd=1 → next cycle out_valid=1, wrtbck_val_o=2, rd_o=7, wrtbck_en_o=1.
- Back-to-back: out_ready held 1, 4 ALU ops on consecutive cycles (SUB 3-5=0xFFFFFFFE, SLT -1<1=1, SLTU 0xFFFFFFFF<1=0, SRA 0x80000000>>4=0xF8000000) → 4 results on 4 consecutive cycles, in order.
- MUL 0x0000FFFF*0x00010001 (DATA_WIDTH=32): in_ready=0 for 32 cycles, then out_valid with 0xFFFFFFFF; without EXEU_MC_MUL_EN: 1 cycle, 0, wrtbck_en_o=0.
- Backpressure: out_ready=0 for 5 cycles after a result → outputs stable, in_ready=0; out_ready=1 → transfer, then IDLE.
- rd=0 with use_rd=1, and op=13 → wrtbck_en_o=0 in both cases, out_valid still asserted.
- rst_n asserted at BUSY cycle 10 → out_valid=0 and all outputs 0 immediately; after release in_ready=1 and no stale result appears.
